uart_reg_send: RTL and testbench

UART_REG_SEND -- requirements
Module: uart_reg_send

---
 rtl/uart_reg_pkg.sv | 29 ++
 rtl/uart_reg_send.sv | 128 ++++++++++++
 tb/tb_uart_reg_send.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_reg_pkg.sv
// ============================================================================
// uart_reg_pkg : shared byte width and FSM state type for uart_reg_send
// Optional feature macro: UART_REG_SEND_CHECKSUM_EN
// Revision: 1.0
// ============================================================================
`default_nettype none

package uart_reg_pkg;

    localparam int UART_BYTE_W = 8;

`ifdef UART_REG_SEND_CHECKSUM_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        CSUM = 2'd2,
        DONE = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;
`endif

endpackage

`default_nettype wire

// File: rtl/uart_reg_send.sv
// ============================================================================
// uart_reg_send : serializes a REG_SIZE-bit word MSB byte first to a UART
// byte transmitter. Optional trailing XOR byte via UART_REG_SEND_CHECKSUM_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_reg_send
    import uart_reg_pkg::*;
#(
    parameter int REG_SIZE = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [REG_SIZE-1:0]    reg_data,
    input  logic                   reg_valid,
    output logic                   reg_busy,
    output logic                   reg_done,
    output logic [UART_BYTE_W-1:0] tx_data,
    output logic                   tx_data_valid,
    input  logic                   tx_ack
);

    localparam int NBYTES = REG_SIZE / UART_BYTE_W;
    localparam int CNT_W  = $clog2(NBYTES + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBYTES - 1);

    generate
        if ((REG_SIZE % UART_BYTE_W) != 0 || REG_SIZE < 8 || REG_SIZE > 2048) begin : g_bad_size
            $error("uart_reg_send: REG_SIZE must be a multiple of 8 in 8..2048");
        end
    endgenerate

    state_t                 state;
    state_t                 state_nxt;
    logic [REG_SIZE-1:0]    shift_reg;
    logic [CNT_W-1:0]       byte_cnt;
    logic [UART_BYTE_W-1:0] head_byte;
    logic                   capture;
    logic                   byte_ack;
    logic                   last_byte;

    assign head_byte = shift_reg[REG_SIZE-1 -: UART_BYTE_W];
    assign capture   = (state == IDLE) && reg_valid;
    assign byte_ack  = (state == SEND) && tx_ack;
    assign last_byte = (byte_cnt == LAST_IDX);

`ifdef UART_REG_SEND_CHECKSUM_EN
    logic [UART_BYTE_W-1:0] csum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum <= '0;
        end else if (capture) begin
            csum <= '0;
        end else if (byte_ack) begin
            csum <= csum ^ head_byte;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath: the head byte is always the next one to go out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
            byte_cnt  <= '0;
        end else if (capture) begin
            shift_reg <= reg_data;
            byte_cnt  <= '0;
        end else if (byte_ack) begin
            shift_reg <= shift_reg << UART_BYTE_W;
            byte_cnt  <= byte_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        state_nxt     = state;
        reg_busy      = (state != IDLE);
        reg_done      = 1'b0;
        tx_data_valid = 1'b0;
        tx_data       = '0;
        case (state)
            IDLE: begin
                if (reg_valid) begin
                    state_nxt = SEND;
                end
            end
            SEND: begin
                tx_data_valid = 1'b1;
                tx_data       = head_byte;
                if (tx_ack && last_byte) begin
`ifdef UART_REG_SEND_CHECKSUM_EN
                    state_nxt = CSUM;
`else
                    state_nxt = DONE;
`endif
                end
            end
`ifdef UART_REG_SEND_CHECKSUM_EN
            CSUM: begin
                tx_data_valid = 1'b1;
                tx_data       = csum;
                if (tx_ack) begin
                    state_nxt = DONE;
                end
            end
`endif
            DONE: begin
                reg_done  = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_reg_send.sv
// ============================================================================
// tb_uart_reg_send : queue-based reference model plus directed and random
// stimulus for uart_reg_send (REG_SIZE = 32).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_uart_reg_send;

    localparam int REG_SIZE = 32;
    localparam int NB       = REG_SIZE / 8;

    logic                clk       = 1'b0;
    logic                rst_n     = 1'b1;
    logic [REG_SIZE-1:0] reg_data  = '0;
    logic                reg_valid = 1'b0;
    logic                tx_ack    = 1'b0;
    logic                reg_busy;
    logic                reg_done;
    logic [7:0]          tx_data;
    logic                tx_data_valid;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_reg_send #(.REG_SIZE(REG_SIZE)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .reg_data      (reg_data),
        .reg_valid     (reg_valid),
        .reg_busy      (reg_busy),
        .reg_done      (reg_done),
        .tx_data       (tx_data),
        .tx_data_valid (tx_data_valid),
        .tx_ack        (tx_ack)
    );

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: a word becomes a queue of bytes still owed to the
    // transmitter; phase 0 = idle, 1 = bytes pending, 2 = done pulse.
    logic [7:0] exp_q[$];
    int         phase = 0;

    function automatic void load_word(input logic [REG_SIZE-1:0] w);
        logic [7:0] x;
        x = 8'h00;
        exp_q.delete();
        for (int i = NB - 1; i >= 0; i--) begin
            exp_q.push_back(w[i*8 +: 8]);
            x = x ^ w[i*8 +: 8];
        end
`ifdef UART_REG_SEND_CHECKSUM_EN
        exp_q.push_back(x);
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase = 0;
            exp_q.delete();
        end else begin
            case (phase)
                0: if (reg_valid) begin
                    load_word(reg_data);
                    phase = 1;
                end
                1: if (tx_ack) begin
                    void'(exp_q.pop_front());
                    if (exp_q.size() == 0) phase = 2;
                end
                default: phase = 0;
            endcase
        end
    end

    // Per-cycle comparison plus a log of bytes actually handed over.
    logic [7:0] dut_log[$];
    int         dut_done = 0;

    always @(negedge clk) begin
        logic [7:0] ed;
        ed = (phase == 1 && exp_q.size() > 0) ? exp_q[0] : 8'h00;
        check("tx_data_valid", {31'd0, tx_data_valid}, {31'd0, phase == 1});
        check("tx_data", {24'd0, tx_data}, {24'd0, ed});
        check("reg_busy", {31'd0, reg_busy}, {31'd0, phase != 0});
        check("reg_done", {31'd0, reg_done}, {31'd0, phase == 2});
        if (tx_data_valid && tx_ack) dut_log.push_back(tx_data);
        if (reg_done) dut_done++;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Send one word; ack_mod = 1 acks every cycle, N acks every Nth cycle.
    task automatic send_word(input logic [31:0] w, input int ack_mod, input int budget);
        int start_done;
        int cyc;
        start_done = dut_done;
        cyc        = 0;
        reg_data   = w;
        reg_valid  = 1'b1;
        tick();
        reg_valid  = 1'b0;
        while (dut_done == start_done && cyc < budget) begin
            tx_ack = (ack_mod <= 1) ? 1'b1 : ((cyc % ack_mod) == ack_mod - 1);
            tick();
            cyc++;
        end
        tx_ack = 1'b0;
        check("word_done_timeout", {31'd0, dut_done != start_done}, 32'd1);
    endtask

    function automatic void check_bytes(input string name, input logic [31:0] word_lit, input logic [7:0] csum_lit);
        int n;
        n = NB;
`ifdef UART_REG_SEND_CHECKSUM_EN
        n = NB + 1;
        if (dut_log.size() > NB) check({name, "_csum"}, {24'd0, dut_log[NB]}, {24'd0, csum_lit});
`endif
        check({name, "_count"}, dut_log.size(), n);
        for (int i = 0; i < NB; i++) begin
            if (i < dut_log.size()) check({name, "_byte"}, {24'd0, dut_log[i]}, {24'd0, word_lit[31-8*i -: 8]});
        end
    endfunction

    initial begin
        int d0;
        int cyc;
        #1 rst_n = 1'b0;
        tick();
        check("reset_busy", {31'd0, reg_busy}, 32'd0);
        check("reset_valid", {31'd0, tx_data_valid}, 32'd0);
        check("reset_data", {24'd0, tx_data}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Basic word, ack every third cycle
        dut_log.delete();
        d0 = dut_done;
        send_word(32'hA1B2C3D4, 3, 200);
        check_bytes("basic", 32'hA1B2C3D4, 8'h04);
        check("basic_done_once", dut_done - d0, 32'd1);
        tick();

        // Back-pressure: first byte held for 20 cycles without ack
        dut_log.delete();
        reg_data  = 32'hA1B2C3D4;
        reg_valid = 1'b1;
        tick();
        reg_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            check("bp_data", {24'd0, tx_data}, 32'h0000_00A1);
            check("bp_valid", {31'd0, tx_data_valid}, 32'd1);
            tick();
        end
        d0 = dut_done;
        tx_ack = 1'b1;
        cyc = 0;
        while (dut_done == d0 && cyc < 50) begin tick(); cyc++; end
        tx_ack = 1'b0;
        check_bytes("bp", 32'hA1B2C3D4, 8'h04);
        tick();

        // Ignored request while busy
        dut_log.delete();
        reg_data  = 32'hA1B2C3D4;
        reg_valid = 1'b1;
        tick();
        reg_data  = 32'h11223344;
        d0 = dut_done;
        cyc = 0;
        while (dut_done == d0 && cyc < 100) begin
            reg_valid = (cyc < 3);
            tx_ack    = cyc[0];
            tick();
            cyc++;
        end
        reg_valid = 1'b0;
        tx_ack    = 1'b0;
        repeat (3) tick();
        check("ign_idle_busy", {31'd0, reg_busy}, 32'd0);
        check_bytes("ign", 32'hA1B2C3D4, 8'h04);
        dut_log.delete();
        send_word(32'h11223344, 2, 100);
        check_bytes("ign_second", 32'h11223344, 8'h44);
        tick();

        // Reset in the middle of a word, after the B2 ack
        dut_log.delete();
        d0 = dut_done;
        reg_data  = 32'hA1B2C3D4;
        reg_valid = 1'b1;
        tick();
        reg_valid = 1'b0;
        tx_ack    = 1'b1;
        tick();
        tick();
        tx_ack = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("rst_busy", {31'd0, reg_busy}, 32'd0);
        check("rst_valid", {31'd0, tx_data_valid}, 32'd0);
        check("rst_data", {24'd0, tx_data}, 32'd0);
        check("rst_done", {31'd0, reg_done}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        check("rst_no_done", dut_done - d0, 32'd0);
        check("rst_bytes", dut_log.size(), 32'd2);
        dut_log.delete();
        send_word(32'h0000_00FF, 1, 50);
        check_bytes("after_rst", 32'h0000_00FF, 8'hFF);
        tick();

        dut_log.delete();
        send_word(32'h0102_0304, 1, 50);
        check_bytes("csum_word", 32'h0102_0304, 8'h04);
        tick();

        // Continuous ack with reg_valid held: back-to-back words
        dut_log.delete();
        d0 = dut_done;
        reg_data  = 32'h5A5A_C33C;
        reg_valid = 1'b1;
        tx_ack    = 1'b1;
        cyc = 0;
        while (dut_done - d0 < 2 && cyc < 100) begin tick(); cyc++; end
        reg_valid = 1'b0;
        tx_ack    = 1'b0;
        check("b2b_words", dut_done - d0, 32'd2);
`ifdef UART_REG_SEND_CHECKSUM_EN
        check("b2b_bytes", dut_log.size(), 2 * (NB + 1));
`else
        check("b2b_bytes", dut_log.size(), 2 * NB);
`endif
        tick();
        tick();

        // Random traffic, checked cycle by cycle against the model
        for (int i = 0; i < 600; i++) begin
            reg_valid = ($urandom_range(0, 3) == 0);
            reg_data  = $urandom();
            tx_ack    = $urandom_range(0, 1);
            tick();
        end
        reg_valid = 1'b0;
        tx_ack    = 1'b1;
        cyc = 0;
        while (reg_busy && cyc < 50) begin tick(); cyc++; end
        check("drain_idle", {31'd0, reg_busy}, 32'd0);
        tx_ack = 1'b0;
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
